// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: FSM state encoding,
// requester id, and the WAIT_RD timeout counter sizing.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    // Requester 0 is the APB slave side, requester 1 the DMA / test engine.
    typedef logic req_id_t;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W           = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/sram_arb_rr_picker.sv
// Grant selection between the two requesters. Round-robin on contention by default;
// with SRAM_ARB_FIXED_PRIO_EN defined, requester 0 always wins and no history is kept.
module sram_arb_rr_picker
    import sram_arb_pkg::*;
(
    input  logic    PCLK,
    input  logic    PRESETn,
    input  logic    valid0_i,
    input  logic    valid1_i,
    input  logic    take_i,
    output logic    grant_vld_o,
    output req_id_t grant_id_o
);

    assign grant_vld_o = valid0_i | valid1_i;

`ifdef SRAM_ARB_FIXED_PRIO_EN

    assign grant_id_o = valid0_i ? 1'b0 : 1'b1;

    logic unused_ok;
    assign unused_ok = ^{PCLK, PRESETn, take_i};

`else

    req_id_t last_grant_q;
    req_id_t last_grant_d;

    always_comb begin
        if (valid0_i && valid1_i) begin
            grant_id_o = other_req(last_grant_q);
        end else if (valid1_i) begin
            grant_id_o = 1'b1;
        end else begin
            grant_id_o = 1'b0;
        end
    end

    // History only moves when the grant is actually taken by the FSM.
    assign last_grant_d = (take_i && grant_vld_o) ? grant_id_o : last_grant_q;

    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-ported SRAM between the APB side (req0) and a DMA/test engine (req1).
// Optional build macro: SRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [STRB_WIDTH-1:0] req0_strb,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [STRB_WIDTH-1:0] req1_strb,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,

    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write,
    output logic [STRB_WIDTH-1:0] mem_strb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam cnt_t TO_CNT = cnt_t'(TIMEOUT);

    state_t                  state_q;
    req_id_t                 owner_q;
    cnt_t                    cnt_q;
    cnt_t                    cnt_d;

    logic                    mem_req_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_write_q;
    logic [STRB_WIDTH-1:0]   mem_strb_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    logic                    req0_done_q;
    logic                    req1_done_q;
    logic                    req0_err_q;
    logic                    req1_err_q;
    logic [DATA_WIDTH-1:0]   req0_rdata_q;
    logic [DATA_WIDTH-1:0]   req1_rdata_q;

    logic                    idle;
    logic                    grant_vld;
    req_id_t                 grant_id;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [STRB_WIDTH-1:0]   sel_strb;
    logic                    rd_finish;
    logic [DATA_WIDTH-1:0]   rd_result;

    assign idle = (state_q == ST_IDLE);

    sram_arb_rr_picker u_picker (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .valid0_i    (req0_valid),
        .valid1_i    (req1_valid),
        .take_i      (idle),
        .grant_vld_o (grant_vld),
        .grant_id_o  (grant_id)
    );

    // Ready is combinational and masked while reset is held so no command slips in.
    assign req0_ready = PRESETn & idle & grant_vld & (grant_id == 1'b0);
    assign req1_ready = PRESETn & idle & grant_vld & (grant_id == 1'b1);

    assign sel_write = grant_id ? req1_write : req0_write;
    assign sel_addr  = grant_id ? req1_addr  : req0_addr;
    assign sel_wdata = grant_id ? req1_wdata : req0_wdata;
    assign sel_strb  = grant_id ? req1_strb  : req0_strb;

    assign cnt_d     = cnt_q + cnt_t'(1);
    // A read finishes on returned data or when the no-data count hits TIMEOUT.
    assign rd_finish = mem_rvalid || (cnt_d == TO_CNT);
    assign rd_result = mem_rvalid ? mem_rdata : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_write_q  <= 1'b0;
            mem_strb_q   <= '0;
            mem_wdata_q  <= '0;
            req0_done_q  <= 1'b0;
            req1_done_q  <= 1'b0;
            req0_err_q   <= 1'b0;
            req1_err_q   <= 1'b0;
            req0_rdata_q <= '0;
            req1_rdata_q <= '0;
        end else begin
            mem_req_q   <= 1'b0;
            req0_done_q <= 1'b0;
            req1_done_q <= 1'b0;
            req0_err_q  <= 1'b0;
            req1_err_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        owner_q     <= grant_id;
                        mem_req_q   <= 1'b1;
                        mem_write_q <= sel_write;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_strb_q  <= sel_strb;
                        state_q     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (mem_write_q) begin
                        if (owner_q) begin
                            req1_done_q <= 1'b1;
                        end else begin
                            req0_done_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_RD;
                    end
                end

                ST_WAIT_RD: begin
                    if (rd_finish) begin
                        if (owner_q) begin
                            req1_done_q  <= 1'b1;
                            req1_err_q   <= ~mem_rvalid;
                            req1_rdata_q <= rd_result;
                        end else begin
                            req0_done_q  <= 1'b1;
                            req0_err_q   <= ~mem_rvalid;
                            req0_rdata_q <= rd_result;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_write  = mem_write_q;
    assign mem_strb   = mem_strb_q;
    assign mem_wdata  = mem_wdata_q;
    assign req0_done  = req0_done_q;
    assign req1_done  = req1_done_q;
    assign req0_err   = req0_err_q;
    assign req1_err   = req1_err_q;
    assign req0_rdata = req0_rdata_q;
    assign req1_rdata = req1_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: fixed vector table, hand sequences for
// reset/timeout/drop-valid corners, then random transactions against a transaction-level model.
module tb_sram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = 4;
    localparam int TO = 15;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req0_valid, req0_ready, req0_write, req0_done, req0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic [SW-1:0] req0_strb;
    logic          req1_valid, req1_ready, req1_write, req1_done, req1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic [SW-1:0] req1_strb;
    logic          mem_req, mem_write, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_strb;
    logic [DW-1:0] mem_wdata, mem_rdata;

    sram_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_strb(req0_strb),
        .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_strb(req1_strb),
        .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_strb(mem_strb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } cmd_t;

    typedef struct {
        logic          v0;
        logic          v1;
        cmd_t          c0;
        cmd_t          c1;
        int            lat;        // WAIT_RD cycle index carrying rvalid, -1 = never
        logic [DW-1:0] rdv;        // data the SRAM returns
        int            exp_id;
        logic [DW-1:0] exp_rdata;  // owner's rdata after done
        logic          exp_err;
    } vec_t;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [DW-1:0] rd_model [2];
    int            last_m;
    logic [DW-1:0] mem_model [256];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arbitration rule from the requester's point of view.
    function automatic int pick(input logic v0, input logic v1);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        return v0 ? 0 : 1;
`else
        if (v0 && v1) return (last_m == 1) ? 0 : 1;
        return v0 ? 0 : 1;
`endif
    endfunction

    function automatic vec_t mk(input logic v0, input logic v1, input logic wr,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [SW-1:0] st, input int lat, input logic [DW-1:0] rdv,
                                input int id, input logic [DW-1:0] er, input logic ee);
        vec_t r;
        cmd_t w, o;
        w = '{wr, a, wd, st};
        o = '{~wr, a ^ 8'hFF, ~wd, ~st};
        r.v0 = v0; r.v1 = v1;
        r.c0 = (id == 0) ? w : o;
        r.c1 = (id == 0) ? o : w;
        r.lat = lat; r.rdv = rdv; r.exp_id = id; r.exp_rdata = er; r.exp_err = ee;
        return r;
    endfunction

    task automatic chk_no_done(input string nm);
        chk({nm, "_done0"}, {31'b0, req0_done}, 0);
        chk({nm, "_done1"}, {31'b0, req1_done}, 0);
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_txn(input vec_t v);
        cmd_t w;
        int   oth;
        int   nwait;
        w   = (v.exp_id == 1) ? v.c1 : v.c0;
        oth = 1 - v.exp_id;
        req0_valid = v.v0; req0_write = v.c0.wr; req0_addr = v.c0.addr;
        req0_wdata = v.c0.wdata; req0_strb = v.c0.strb;
        req1_valid = v.v1; req1_write = v.c1.wr; req1_addr = v.c1.addr;
        req1_wdata = v.c1.wdata; req1_strb = v.c1.strb;
        #1;
        chk("ready0", {31'b0, req0_ready}, (v.exp_id == 0) ? 1 : 0);
        chk("ready1", {31'b0, req1_ready}, (v.exp_id == 1) ? 1 : 0);
        @(posedge PCLK); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("mem_req", {31'b0, mem_req}, 1);
        chk("mem_addr", {24'b0, mem_addr}, {24'b0, w.addr});
        chk("mem_write", {31'b0, mem_write}, {31'b0, w.wr});
        chk("mem_wdata", mem_wdata, w.wdata);
        chk("mem_strb", {28'b0, mem_strb}, {28'b0, w.strb});
        chk_no_done("issue");
        if (!w.wr) begin
            nwait = (v.lat < 0) ? TO : v.lat + 1;
            for (int k = 0; k < nwait; k++) begin
                @(posedge PCLK); #1;
                chk("wait_mem_req", {31'b0, mem_req}, 0);
                chk_no_done("wait");
                mem_rvalid = (k == v.lat);
                mem_rdata  = (k == v.lat) ? v.rdv : $urandom;
            end
        end
        @(posedge PCLK); #1;
        mem_rvalid = 1'b0;
        chk("owner_done", {31'b0, (v.exp_id == 1) ? req1_done : req0_done}, 1);
        chk("other_done", {31'b0, (oth == 1) ? req1_done : req0_done}, 0);
        chk("owner_rdata", (v.exp_id == 1) ? req1_rdata : req0_rdata, v.exp_rdata);
        chk("owner_err", {31'b0, (v.exp_id == 1) ? req1_err : req0_err}, {31'b0, v.exp_err});
        chk("other_rdata", (oth == 1) ? req1_rdata : req0_rdata, rd_model[oth]);
        rd_model[v.exp_id] = v.exp_rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [6];
        vec_t v;
        int   id;
        logic [DW-1:0] er;

        PRESETn = 1'b0;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_strb = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_strb = 0;
        mem_rvalid = 0; mem_rdata = 0;
        rd_model[0] = 0; rd_model[1] = 0; last_m = 1;
        for (int i = 0; i < 256; i++) mem_model[i] = $urandom;

        // Reset state, with requests pending to show ready is masked.
        repeat (2) @(posedge PCLK);
        #1;
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_ready0", {31'b0, req0_ready}, 0);
        chk("rst_ready1", {31'b0, req1_ready}, 0);
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_mem_addr", {24'b0, mem_addr}, 0);
        chk("rst_rdata0", req0_rdata, 0);
        chk("rst_rdata1", req1_rdata, 0);
        chk_no_done("rst");
        req0_valid = 0; req1_valid = 0;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        chk("post_rst_mem_req", {31'b0, mem_req}, 0);

        tbl[0] = mk(1, 0, 1, 8'h10, 32'hDEADBEEF, 4'hF,  0, 32'h0,        0, 32'h0,        0);
        tbl[1] = mk(0, 1, 0, 8'h20, 32'h0,        4'h0,  2, 32'h12345678, 1, 32'h12345678, 0);
        tbl[2] = mk(1, 0, 0, 8'h10, 32'h0,        4'hF,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
        tbl[3] = mk(0, 1, 1, 8'h33, 32'hA5A50000, 4'hC,  0, 32'h0,        1, 32'h12345678, 0);
        tbl[4] = mk(1, 0, 0, 8'h44, 32'h0,        4'h0, -1, 32'h0,        0, 32'h0,        1);
        tbl[5] = mk(0, 1, 1, 8'h55, 32'h0BAD0BAD, 4'h0,  0, 32'h0,        1, 32'h12345678, 0);
        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i]);
            last_m = tbl[i].exp_id;
        end

        // Continuous contention: alternates under round-robin, always req0 under fixed priority.
        for (int i = 0; i < 4; i++) begin
            id = pick(1, 1);
            run_txn(mk(1, 1, 1, 8'(8'h60 + i), 32'h1000 + i, 4'hF, 0, 0, id, rd_model[id], 0));
            last_m = id;
        end

        // Timeout, then a late rvalid while idle must be ignored.
        run_txn(mk(0, 1, 0, 8'h66, 32'h0, 4'h0, -1, 32'h0, 1, 32'h0, 1));
        last_m = 1;
        mem_rvalid = 1; mem_rdata = 32'h5A5A5A5A;
        @(posedge PCLK); #1;
        mem_rvalid = 0;
        chk_no_done("late_rvalid");
        @(posedge PCLK); #1;
        chk_no_done("late_rvalid2");
        id = pick(1, 1);
        run_txn(mk(1, 1, 1, 8'h67, 32'h77, 4'h1, 0, 0, id, rd_model[id], 0));
        last_m = id;

        // req0 raises valid while req1 owns the SRAM, then withdraws: no access for req0.
        req1_valid = 1; req1_write = 0; req1_addr = 8'h70;
        #1;
        chk("drop_ready1", {31'b0, req1_ready}, 1);
        @(posedge PCLK); #1;
        req1_valid = 0;
        req0_valid = 1; req0_write = 1; req0_addr = 8'h71; req0_wdata = 32'h99; req0_strb = 4'hF;
        #1;
        chk("drop_ready0_issue", {31'b0, req0_ready}, 0);
        chk("drop_mem_addr", {24'b0, mem_addr}, 32'h70);
        @(posedge PCLK); #1;
        chk("drop_ready0_wait", {31'b0, req0_ready}, 0);
        req0_valid = 0;
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        @(posedge PCLK); #1;
        mem_rvalid = 0;
        chk("drop_done1", {31'b0, req1_done}, 1);
        chk("drop_rdata1", req1_rdata, 32'hCAFEF00D);
        chk("drop_done0", {31'b0, req0_done}, 0);
        rd_model[1] = 32'hCAFEF00D; last_m = 1;
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = (i == 1);
            @(posedge PCLK); #1;
            chk("drop_idle_mem_req", {31'b0, mem_req}, 0);
            chk("drop_idle_mem_addr", {24'b0, mem_addr}, 32'h70);
            chk_no_done("drop_idle");
        end
        mem_rvalid = 0;

        // Asynchronous reset in the middle of WAIT_RD.
        req1_valid = 1; req1_write = 0; req1_addr = 8'h21;
        @(posedge PCLK); #1;
        req1_valid = 0;
        repeat (2) begin
            @(posedge PCLK); #1;
        end
        #2;
        PRESETn = 1'b0;
        #1;
        chk("arst_mem_req", {31'b0, mem_req}, 0);
        chk("arst_mem_addr", {24'b0, mem_addr}, 0);
        chk("arst_rdata1", req1_rdata, 0);
        chk("arst_rdata0", req0_rdata, 0);
        chk_no_done("arst");
        req0_valid = 1; req1_valid = 1;
        mem_rvalid = 1; mem_rdata = 32'h11112222;
        #1;
        chk("arst_ready0", {31'b0, req0_ready}, 0);
        chk("arst_ready1", {31'b0, req1_ready}, 0);
        @(posedge PCLK);
        @(posedge PCLK); #1;
        req0_valid = 0; req1_valid = 0;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        mem_rvalid = 0;
        chk_no_done("arst_after");
        chk("arst_after_mem_req", {31'b0, mem_req}, 0);
        rd_model[0] = 0; rd_model[1] = 0; last_m = 1;
        run_txn(mk(1, 1, 1, 8'h22, 32'h3333, 4'h3, 0, 0, 0, 32'h0, 0));
        last_m = 0;

        // Random traffic against the transaction-level model; the bench also plays the SRAM.
        for (int i = 0; i < 200; i++) begin
            v.v0 = 1'($urandom);
            v.v1 = 1'($urandom);
            if (!v.v0 && !v.v1) v.v0 = 1'b1;
            v.c0 = '{1'($urandom), 8'($urandom), $urandom, 4'($urandom)};
            v.c1 = '{1'($urandom), 8'($urandom), $urandom, 4'($urandom)};
            id = pick(v.v0, v.v1);
            v.exp_id = id;
            v.lat = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            if ((id == 1) ? v.c1.wr : v.c0.wr) begin
                cmd_t w;
                w = (id == 1) ? v.c1 : v.c0;
                for (int b = 0; b < SW; b++)
                    if (w.strb[b]) mem_model[w.addr][8*b +: 8] = w.wdata[8*b +: 8];
                v.rdv = 0; v.exp_rdata = rd_model[id]; v.exp_err = 0;
            end else begin
                v.rdv = mem_model[(id == 1) ? v.c1.addr : v.c0.addr];
                er = (v.lat < 0) ? 32'h0 : v.rdv;
                v.exp_rdata = er; v.exp_err = (v.lat < 0);
            end
            run_txn(v);
            last_m = id;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge PCLK); #1;
                chk_no_done("rand_gap");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
